// File: rtl/word16_to_nib4_fifo.sv
// rtl/word16_to_nib4_fifo.sv - single-clock FIFO taking 16-bit words, emitting 4-bit nibbles LSB-first
module word16_to_nib4_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [15:0]   DIW,
  input  logic          WEW,
  output logic          RDYW,
  output logic [3:0]    DON,
  output logic          VALN,
  input  logic          ENN,
  output logic          LASTN,
  output logic [AW:0]   WCOUNT,
  output logic          OVF
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [1:0]    nib_q, nib_d;
  logic [AW:0]   wcount_q, wcount_d;
  logic          ovf_q, ovf_d;

  logic          wr_acc;
  logic          rd_take;
  logic          retire;
  logic [15:0]   head;

  // Status is decoded only from the held-word count; pointers may be equal when full or empty.
  always_comb begin
    RDYW    = (wcount_q != FULL);
    VALN    = (wcount_q != '0);
    head    = mem_q[rptr_q];
    DON     = VALN ? head[{nib_q, 2'b00} +: 4] : 4'h0;
    LASTN   = VALN && (nib_q == 2'd3);
    WCOUNT  = wcount_q;
    OVF     = ovf_q;
    wr_acc  = WEW && RDYW;
    rd_take = VALN && ENN;
    retire  = rd_take && (nib_q == 2'd3);
  end

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    nib_d    = nib_q;
    wcount_d = wcount_q;
    ovf_d    = ovf_q;
    if (wr_acc) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (WEW && !RDYW) begin
      ovf_d = 1'b1;
    end
    if (rd_take) begin
      nib_d = nib_q + 2'd1;
    end
    if (retire) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (wr_acc && !retire) begin
      wcount_d = wcount_q + 1'b1;
    end else if (retire && !wr_acc) begin
      wcount_d = wcount_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      nib_q    <= '0;
      wcount_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      nib_q    <= nib_d;
      wcount_q <= wcount_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge CLK) begin
    if (RSTN && wr_acc) begin
      mem_q[wptr_q] <= DIW;
    end
  end

endmodule
